spi_controller: RTL and testbench

SPI mode-0 initiator that issues 16-bit register-write (and optional read) frames to the chip's SPI register peripheral. Frame format: 1 R/W bit, then a 7-bit address, then 8 data bits. R/W = 1 means write. All fields are sent MSB first. The block sits on the test/config side: a local command interface hands it one frame at a time, and it generates sclk/ncs/copi from the fast system clock. For read frames it captures cipo during the data phase.

---
 rtl/spi_controller.sv | 153 +++++++++++++++
 tb/tb_spi_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends 16-bit {rw, addr[6:0], data[7:0]} frames MSB first,
// captures cipo during the data byte of read frames.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_idx, bit_nxt;
  logic [15:0]      frame;
  logic [7:0]       rd_shift;
  logic [1:0]       cipo_sync;
  logic             phase_end, take, capture, next_bit, frame_done, to_idle;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign sclk      = (state == SHIFT_HI);
  assign ncs       = (state == IDLE) || (state == GAP);
  assign phase_end = (cnt == DIV_LAST);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    take       = 1'b0;
    capture    = 1'b0;
    next_bit   = 1'b0;
    frame_done = 1'b0;
    to_idle    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = SHIFT_LO;
          cnt_nxt   = '0;
          bit_nxt   = 4'd15;
          take      = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          state_nxt = SHIFT_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          cnt_nxt = '0;
          // Data byte occupies bit indices 7..0; frame[15]==0 marks a read
          capture = !frame[15] && !bit_idx[3];
          if (bit_idx == 4'd0) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = SHIFT_LO;
            bit_nxt   = bit_idx - 4'd1;
            next_bit  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_nxt  = GAP;
          cnt_nxt    = '0;
          frame_done = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          to_idle   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
    end
  end

  // copi leads sclk by a full low phase, so it changes only when a new bit starts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      copi     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_valid <= 1'b0;
      if (take) begin
        copi <= cmd_rw;
      end else if (next_bit) begin
        copi <= frame[bit_idx - 4'd1];
      end else if (to_idle) begin
        copi <= 1'b0;
      end
      if (frame_done && !frame[15]) begin
        rd_valid <= 1'b1;
        rd_data  <= rd_shift;
      end
    end
  end

  // cipo is asynchronous; two flops settle it well inside the sclk-high phase
  always_ff @(posedge clk) begin
    cipo_sync <= {cipo_sync[0], cipo};
    if (take) begin
      frame <= {cmd_rw, cmd_addr, cmd_data};
    end
    if (capture) begin
      rd_shift <= {rd_shift[6:0], cipo_sync[1]};
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: timeline model of each frame, peripheral/cipo models,
// directed plan cases, randomized frames with resets, and a CLK_DIV=3 instance.
module tb_spi_controller;
  localparam int D  = 4;
  localparam int G  = 4;
  localparam int FL = 33 * D;
  localparam int GL = 33 * D + G;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid, cmd_rw, cipo;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_ready, rd_valid, busy, sclk, ncs, copi;
  logic [7:0] rd_data;

  logic       cmd_valid3, cmd_rw3, cipo3;
  logic [6:0] cmd_addr3;
  logic [7:0] cmd_data3;
  logic       cmd_ready3, rd_valid3, busy3, sclk3, ncs3, copi3;
  logic [7:0] rd_data3;

  spi_controller u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo)
  );

  spi_controller #(.CLK_DIV(3), .GAP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_rw(cmd_rw3), .cmd_addr(cmd_addr3), .cmd_data(cmd_data3),
    .rd_valid(rd_valid3), .rd_data(rd_data3), .busy(busy3),
    .sclk(sclk3), .ncs(ncs3), .copi(copi3), .cipo(cipo3)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame timeline model ----------------
  bit          armed = 0;
  bit          live = 0;
  int          t = 0;
  logic [15:0] m_frame = '0;
  logic [7:0]  m_rd_src = '0;
  logic [7:0]  rd_exp = '0;
  logic [7:0]  rd_src = '0;
  int          hs_cnt = 0;
  longint      cyc = 0;
  longint      hs_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        if (live) begin
          check("ncs", ncs, t > FL);
          check("sclk", sclk, (t <= 32 * D) && (((t - 1) / D) % 2 == 1));
          if (t <= FL)
            check("copi", copi, (t <= 32 * D) ? m_frame[15 - (t - 1) / (2 * D)] : m_frame[0]);
          check("cmd_ready", cmd_ready, 0);
          check("busy", busy, 1);
          check("rd_valid", rd_valid, !m_frame[15] && (t == FL + 1));
        end else begin
          check("idle_ncs", ncs, 1);
          check("idle_sclk", sclk, 0);
          check("idle_copi", copi, 0);
          check("idle_cmd_ready", cmd_ready, 1);
          check("idle_busy", busy, 0);
          check("idle_rd_valid", rd_valid, 0);
        end
        check("rd_data", rd_data, rd_exp);
      end
      // predict the effect of the coming clock edge
      if (!rst_n) begin
        armed = 1;
        live = 0;
        rd_exp = 8'h00;
      end else if (live) begin
        t++;
        if (t == FL + 1 && !m_frame[15]) rd_exp = m_rd_src;
        if (t == GL + 1) live = 0;
      end else if (cmd_valid) begin
        live = 1;
        t = 1;
        m_frame = {cmd_rw, cmd_addr, cmd_data};
        m_rd_src = rd_src;
        hs_cnt++;
        hs_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- cipo driver: data byte MSB first after sclk falls ----------------
  int   falls = 0;
  logic prev_ncs_c = 1'b1;
  initial begin
    cipo = 1'b0;
    forever begin
      @(negedge sclk or ncs);
      if (ncs !== prev_ncs_c) begin
        prev_ncs_c = ncs;
        falls = 0;
        cipo = 1'($urandom % 2);
      end else if (ncs === 1'b0) begin
        falls++;
        if (falls >= 8 && falls <= 15) cipo = rd_src[15 - falls];
        else cipo = 1'($urandom % 2);
      end
    end
  end

  // ---------------- peripheral register model ----------------
  logic [7:0]  regs [0:4] = '{default: 8'h00};
  logic [15:0] pbuf = '0;
  logic [15:0] wire_last = '0;
  int          rises = 0;
  logic        prev_ncs_p = 1'b1;
  initial begin
    forever begin
      @(posedge sclk or ncs);
      if (ncs !== prev_ncs_p) begin
        prev_ncs_p = ncs;
        if (ncs === 1'b1) begin
          if (rises == 16) begin
            wire_last = pbuf;
            if (pbuf[15] && pbuf[14:8] < 7'd5) regs[int'(pbuf[14:8])] = pbuf[7:0];
          end
        end else if (ncs === 1'b0) begin
          rises = 0;
        end
      end else if (sclk === 1'b1 && ncs === 1'b0) begin
        pbuf = {pbuf[14:0], copi};
        rises++;
      end
    end
  end

  function automatic logic [39:0] regs_flat();
    return {regs[4], regs[3], regs[2], regs[1], regs[0]};
  endfunction

  // ---------------- run-length / pulse monitors ----------------
  int         rdv_pulses = 0, rdv_hr = 0;
  logic [7:0] rdv_data = '0;
  int         low_run = 0, last_low = 0, high_run = 0, last_high = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (ncs === 1'b0) begin
        low_run++;
        if (high_run != 0) begin last_high = high_run; high_run = 0; end
      end else begin
        high_run++;
        if (low_run != 0) begin last_low = low_run; low_run = 0; end
      end
      if (rd_valid === 1'b1) begin
        rdv_pulses++;
        rdv_data = rd_data;
        rdv_hr = high_run;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_hs(input int h0);
    int n = 0;
    while (hs_cnt == h0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (hs_cnt == h0) check("handshake_timeout", hs_cnt, h0 + 1);
    tick();
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d, input logic [7:0] src);
    int h0 = hs_cnt;
    rd_src = src;
    cmd_rw = rw;
    cmd_addr = a;
    cmd_data = d;
    cmd_valid = 1'b1;
    wait_hs(h0);
    cmd_valid = 1'b0;
    cmd_rw = 1'($urandom % 2);
    cmd_addr = 7'($urandom);
    cmd_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (live && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (live) check("idle_timeout", {31'd0, live}, 0);
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] snap;
    int          p0, h0, n;
    int          low3, rises3, rdv3;
    logic [15:0] wire3;
    logic        psclk3;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_valid3 = 1'b0; cmd_rw3 = 1'b0; cmd_addr3 = '0; cmd_data3 = '0; cipo3 = 1'b0;
    repeat (3) tick();
    check("reset_ncs", ncs, 1);
    check("reset_sclk", sclk, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    tick();

    // 1: write 0x80 to addr 0x04
    p0 = rdv_pulses;
    send(1'b1, 7'h04, 8'h80, 8'h00);
    wait_idle();
    check("t1_rises", rises, 16);
    check("t1_ncs_low", last_low, 132);
    check("t1_wire", wire_last, 16'h8480);
    check("t1_pwm_duty", regs[4], 8'h80);
    check("t1_no_rdv", rdv_pulses - p0, 0);

    // 2: read addr 0x02, peripheral returns 0xA5
    snap = regs_flat();
    p0 = rdv_pulses;
    send(1'b0, 7'h02, 8'h00, 8'hA5);
    wait_idle();
    check("t2_rdv_count", rdv_pulses - p0, 1);
    check("t2_rdv_data", rdv_data, 8'hA5);
    check("t2_rdv_on_ncs_rise", rdv_hr, 1);
    check("t2_rd_data", rd_data, 8'hA5);
    check("t2_wire", wire_last, 16'h0200);
    check("t2_regs", regs_flat(), snap);

    // 3: back-to-back writes with cmd_valid held
    h0 = hs_cnt;
    rd_src = 8'h00; cmd_rw = 1'b1; cmd_addr = 7'h00; cmd_data = 8'h3C; cmd_valid = 1'b1;
    wait_hs(h0);
    cmd_addr = 7'h01; cmd_data = 8'hC3;
    wait_hs(h0 + 1);
    cmd_valid = 1'b0;
    wait_idle();
    check("t3_hs_spacing", 32'(hs_cyc[hs_cyc.size() - 1] - hs_cyc[hs_cyc.size() - 2]), 137);
    check("t3_ncs_gap", last_high, 5);
    check("t3_reg0", regs[0], 8'h3C);
    check("t3_reg1", regs[1], 8'hC3);

    // 4: reset after the 8th sclk rise of a write to addr 0x03
    send(1'b1, 7'h03, 8'h5A, 8'h00);
    n = 0;
    while (rises < 8 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rises < 8) check("t4_rise8_timeout", rises, 8);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t4_ncs", ncs, 1);
    check("t4_sclk", sclk, 0);
    check("t4_cmd_ready", cmd_ready, 1);
    #1;
    rst_n = 1'b1;
    tick();
    check("t4_reg3_kept", regs[3], 8'h00);
    send(1'b1, 7'h03, 8'h77, 8'h00);
    wait_idle();
    check("t4_reg3_after", regs[3], 8'h77);

    // 5: write to unmapped addr 0x7F
    snap = regs_flat();
    send(1'b1, 7'h7F, 8'hFF, 8'h00);
    wait_idle();
    check("t5_wire", wire_last, 16'hFFFF);
    check("t5_regs", regs_flat(), snap);

    // randomized frames, occasional reset mid-frame
    for (int i = 0; i < 40; i++) begin
      logic [6:0] a;
      a = ($urandom % 3 == 0) ? 7'($urandom) : 7'($urandom % 5);
      send(1'($urandom % 2), a, 8'($urandom), 8'($urandom));
      if ($urandom % 8 == 0) begin
        repeat ($urandom_range(1, 120)) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      wait_idle();
      repeat ($urandom_range(0, 5)) tick();
    end

    // 6: CLK_DIV=3, GAP_CYCLES=3 instance, write 0x55 to addr 0x00
    low3 = 0; rises3 = 0; rdv3 = 0; wire3 = '0; psclk3 = 1'b0;
    cmd_rw3 = 1'b1; cmd_addr3 = 7'h00; cmd_data3 = 8'h55;
    cmd_valid3 = 1'b1;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (ncs3 === 1'b0) begin
        low3++;
        cmd_valid3 = 1'b0;
        if (sclk3 === 1'b1 && psclk3 === 1'b0) begin
          rises3++;
          wire3 = {wire3[14:0], copi3};
        end
      end
      psclk3 = sclk3;
      if (rd_valid3 === 1'b1) rdv3++;
    end
    check("t6_ncs_low", low3, 99);
    check("t6_rises", rises3, 16);
    check("t6_wire", wire3, 16'h8055);
    check("t6_en_reg_out_7_0", (wire3[15] && wire3[14:8] == 7'h00) ? wire3[7:0] : 8'h00, 8'h55);
    check("t6_no_rdv", rdv3, 0);
    check("t6_cmd_ready", cmd_ready3, 1);
    check("t6_busy", busy3, 0);
    check("t6_rd_data", rd_data3, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
